hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Hazard controller for the 5-stage RV32I pipeline; drives the D/E register's stall (bubble) input.
//  Detects load-use and taken-branch hazards, holds the pipe for multi-cycle E-stage ops,
//  and produces E-stage operand forwarding selects from M and W.
// PARAMETERS
//  LONG_LAT  4  cycles a long op (mul/div) occupies E; legal range 2..16
// PORTS
//  CLK            in   1   clock, rising edge
//  RSTN           in   1   asynchronous active-low reset
//  rs1D, rs2D     in   5   source regs of the instruction in D
//  rs1E, rs2E     in   5   source regs of the instruction in E
//  rdE            in   5   dest reg in E
//  mem_loadE      in   3   load type in E; nonzero = load
//  branch_takenE  in   1   branch/jump in E resolved taken
//  longop_startE  in   1   instruction in E is a multi-cycle op
//  rdM, rdW       in   5   dest regs in M, W
//  reg_writeM/W   in   1   M / W stage writes the register file
//  stallF, stallD out  1   hold PC / F-D register
//  stallE         out  1   hold D/E register contents (long op)
//  flushD         out  1   clear F-D register
//  flushE         out  1   insert bubble into E (to D/E register stall input)
//  flushM         out  1   insert bubble into M
//  fwd1E, fwd2E   out  2   00 = regfile, 01 = from W, 10 = from M
// BEHAVIOUR
//  - Reset (RSTN=0, async): state=IDLE, cnt=0; all outputs forced 0 while RSTN low.
//  - FSM IDLE: longop_startE=1 -> BUSY, cnt<=LONG_LAT-2. BUSY: cnt==0 -> IDLE, else cnt<=cnt-1.
//  - Long op: stallF=stallD=stallE=flushM=1 in the start cycle and every BUSY cycle except
//    the one with cnt==0: exactly LONG_LAT-1 stall cycles, released on cycle LONG_LAT.
//    longop_startE is ignored in BUSY (same instr still held in E; no retrigger).
//  - Load-use: mem_loadE!=0 & rdE!=0 & (rdE==rs1D | rdE==rs2D) -> stallF=stallD=flushE=1
//    for that cycle only; self-clearing because the bubble zeroes mem_loadE.
//  - Taken branch: branch_takenE=1 -> flushD=flushE=1, stallF=stallD=0 (PC redirect wins).
//  - Priority: long-op hold > taken branch > load-use. While stallE=1, flushE=0 and
//    flushD=0 (the long op must survive); load-use is re-evaluated on the release cycle.
//  - Forwarding (combinational, per operand): M match (reg_writeM & rdM!=0 & rdM==rsE) -> 10;
//    else W match (same with W) -> 01; else 00. x0 never forwarded; M beats W.
//  - All hazard outputs are combinational from inputs and state; the only registered
//    state is the FSM and cnt (plus counters below).
// CONFIGURATION
//  HAZ_PERF_CNT_EN defined: adds out ports stall_cnt[31:0] (cycles with stallD=1) and
//    flush_cnt[31:0] (cycles with flushD=1). Both are reset to 0 by RSTN,
//    increment by 1 per qualifying cycle, and wrap from 32'hFFFFFFFF to 0.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  1 lw x5 in E (mem_loadE=3'b010, rdE=5), rs1D=5 -> one cycle stallF=stallD=flushE=1,
//    next cycle all 0.
//  2 Same as 1 but rdE=0 -> no stall; mem_loadE=0 with rdE=rs2D=7 -> no stall.
//  3 branch_takenE=1 together with a load-use match -> flushD=flushE=1, stallF=stallD=0.
//  4 LONG_LAT=4, longop_startE held high 4 cycles -> stallE=flushM=1 for exactly 3 cycles,
//    0 on the 4th; branch_takenE pulsed mid-stall -> flushD=flushE stay 0.
//  5 rs1E=rdM=rdW=9, reg_writeM=reg_writeW=1 -> fwd1E=10; reg_writeM=0 -> 01;
//    rdM=rdW=0 -> 00.
//  6 RSTN low for 1 cycle while in BUSY -> outputs 0 immediately, FSM IDLE; with
//    HAZ_PERF_CNT_EN, 5 load-use stalls -> stall_cnt=5, flush_cnt=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: load-use, taken-branch, long-op hold, E-stage forwarding.
// Optional build macro HAZ_PERF_CNT_EN adds stall_cnt/flush_cnt performance counters.
module hazard_ctrl #(
  parameter int unsigned LONG_LAT = 4
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [4:0]  rs1D,
  input  logic [4:0]  rs2D,
  input  logic [4:0]  rs1E,
  input  logic [4:0]  rs2E,
  input  logic [4:0]  rdE,
  input  logic [2:0]  mem_loadE,
  input  logic        branch_takenE,
  input  logic        longop_startE,
  input  logic [4:0]  rdM,
  input  logic [4:0]  rdW,
  input  logic        reg_writeM,
  input  logic        reg_writeW,
  output logic        stallF,
  output logic        stallD,
  output logic        stallE,
  output logic        flushD,
  output logic        flushE,
  output logic        flushM,
  output logic [1:0]  fwd1E,
`ifdef HAZ_PERF_CNT_EN
  output logic [1:0]  fwd2E,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
`else
  output logic [1:0]  fwd2E
`endif
);

  typedef enum logic {IDLE, BUSY} state_e;

  localparam logic [3:0] CNT_INIT = 4'(LONG_LAT - 2);

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic long_hold;
  logic load_use;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (longop_startE) begin
          state_d = BUSY;
          cnt_d   = CNT_INIT;
        end
      end
      BUSY: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Hold covers the start cycle and every BUSY cycle except the release (cnt==0) one.
  assign long_hold = ((state_q == IDLE) && longop_startE) ||
                     ((state_q == BUSY) && (cnt_q != '0));

  assign load_use = (mem_loadE != '0) && (rdE != '0) &&
                    ((rdE == rs1D) || (rdE == rs2D));

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    if (reg_writeM && (rdM != '0) && (rdM == rs))      return 2'b10;
    else if (reg_writeW && (rdW != '0) && (rdW == rs)) return 2'b01;
    else                                               return 2'b00;
  endfunction

  always_comb begin
    stallF = 1'b0;
    stallD = 1'b0;
    stallE = 1'b0;
    flushD = 1'b0;
    flushE = 1'b0;
    flushM = 1'b0;
    fwd1E  = 2'b00;
    fwd2E  = 2'b00;
    if (RSTN) begin
      fwd1E = fwd_sel(rs1E);
      fwd2E = fwd_sel(rs2E);
      if (long_hold) begin
        stallF = 1'b1;
        stallD = 1'b1;
        stallE = 1'b1;
        flushM = 1'b1;
      end else if (branch_takenE) begin
        flushD = 1'b1;
        flushE = 1'b1;
      end else if (load_use) begin
        stallF = 1'b1;
        stallD = 1'b1;
        flushE = 1'b1;
      end
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + (stallD ? 32'd1 : 32'd0);
    flush_cnt_d = flush_cnt_q + (flushD ? 32'd1 : 32'd0);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios then random traffic against a behavioural model.
module tb_hazard_ctrl;
  localparam int unsigned LONG_LAT = 4;

  logic       CLK = 1'b0;
  logic       RSTN;
  logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic [2:0] mem_loadE;
  logic       branch_takenE, longop_startE, reg_writeM, reg_writeW;
  logic       stallF, stallD, stallE, flushD, flushE, flushM;
  logic [1:0] fwd1E, fwd2E;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] stall_cnt, flush_cnt;
`endif

  always #5 CLK = ~CLK;

  hazard_ctrl #(.LONG_LAT(LONG_LAT)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E), .rdE(rdE),
    .mem_loadE(mem_loadE), .branch_takenE(branch_takenE), .longop_startE(longop_startE),
    .rdM(rdM), .rdW(rdW), .reg_writeM(reg_writeM), .reg_writeW(reg_writeW),
    .stallF(stallF), .stallD(stallD), .stallE(stallE),
    .flushD(flushD), .flushE(flushE), .flushM(flushM),
`ifdef HAZ_PERF_CNT_EN
    .fwd1E(fwd1E), .fwd2E(fwd2E), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`else
    .fwd1E(fwd1E), .fwd2E(fwd2E)
`endif
  );

  typedef struct {
    logic       rstn;
    logic [4:0] rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
    logic [2:0] mem_loadE;
    logic       br, lstart, wM, wW;
  } vec_t;

  typedef struct {
    logic [9:0]  outs;
    logic [31:0] scnt, fcnt;
    int          id;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference state: cycles the current long op still occupies E, and event tallies.
  int unsigned occ  = 0;
  logic [31:0] scnt = '0;
  logic [31:0] fcnt = '0;
  int          cyc  = 0;

  function automatic logic [1:0] ref_fwd(input logic [4:0] rs, input logic [4:0] rm,
                                         input logic wm, input logic [4:0] rw, input logic ww);
    if (rs == 5'd0)            return 2'b00;
    if (wm && rm == rs)        return 2'b10;
    if (ww && rw == rs)        return 2'b01;
    return 2'b00;
  endfunction

  task automatic apply(input vec_t v);
    logic sF, sD, sE, fD, fE, fM, hold, lu;
    exp_t e;
    @(posedge CLK);
    #1;
    RSTN = v.rstn; rs1D = v.rs1D; rs2D = v.rs2D; rs1E = v.rs1E; rs2E = v.rs2E;
    rdE = v.rdE; rdM = v.rdM; rdW = v.rdW; mem_loadE = v.mem_loadE;
    branch_takenE = v.br; longop_startE = v.lstart; reg_writeM = v.wM; reg_writeW = v.wW;
    {sF, sD, sE, fD, fE, fM} = '0;
    e.outs = '0;
    if (!v.rstn) begin
      occ = 0; scnt = '0; fcnt = '0;
    end else begin
      hold = 1'b0;
      if (occ == 0) begin
        if (v.lstart) begin hold = 1'b1; occ = LONG_LAT - 1; end
      end else begin
        hold = (occ > 1);
        occ  = occ - 1;
      end
      lu = (v.mem_loadE != 0) && (v.rdE != 0) && (v.rdE == v.rs1D || v.rdE == v.rs2D);
      if (hold)      begin sF = 1; sD = 1; sE = 1; fM = 1; end
      else if (v.br) begin fD = 1; fE = 1; end
      else if (lu)   begin sF = 1; sD = 1; fE = 1; end
      e.outs = {sF, sD, sE, fD, fE, fM,
                ref_fwd(v.rs1E, v.rdM, v.wM, v.rdW, v.wW),
                ref_fwd(v.rs2E, v.rdM, v.wM, v.rdW, v.wW)};
    end
    e.scnt = scnt;
    e.fcnt = fcnt;
    e.id   = cyc;
    sb.push_back(e);
    scnt = scnt + 32'(sD);
    fcnt = fcnt + 32'(fD);
    cyc++;
  endtask

  function automatic vec_t idle_vec();
    vec_t v;
    v.rstn = 1; v.rs1D = 0; v.rs2D = 0; v.rs1E = 0; v.rs2E = 0; v.rdE = 0;
    v.rdM = 0; v.rdW = 0; v.mem_loadE = 0; v.br = 0; v.lstart = 0; v.wM = 0; v.wW = 0;
    return v;
  endfunction

  function automatic logic [4:0] pick_reg();
    logic [4:0] regs [4] = '{5'd0, 5'd5, 5'd7, 5'd9};
    return regs[$urandom_range(0, 3)];
  endfunction

  // Monitor: outputs are valid once inputs settle; compare away from the active edge.
  initial begin
    forever begin
      @(negedge CLK);
      if (sb.size() > 0) begin
        exp_t e;
        logic [9:0] act;
        e = sb.pop_front();
        act = {stallF, stallD, stallE, flushD, flushE, flushM, fwd1E, fwd2E};
        n_tests++;
        if (act !== e.outs) begin
          n_fail++;
          $display("FAIL outs cyc=%0d actual=%b required=%b (sF sD sE fD fE fM fwd1 fwd2)",
                   e.id, act, e.outs);
        end
`ifdef HAZ_PERF_CNT_EN
        n_tests++;
        if (stall_cnt !== e.scnt || flush_cnt !== e.fcnt) begin
          n_fail++;
          $display("FAIL perf_cnt cyc=%0d actual=%0d/%0d required=%0d/%0d",
                   e.id, stall_cnt, flush_cnt, e.scnt, e.fcnt);
        end
`endif
      end
    end
  end

  initial begin
    vec_t v;
    int   guard;
    RSTN = 0; rs1D = 0; rs2D = 0; rs1E = 0; rs2E = 0; rdE = 0; rdM = 0; rdW = 0;
    mem_loadE = 0; branch_takenE = 0; longop_startE = 0; reg_writeM = 0; reg_writeW = 0;

    v = idle_vec(); v.rstn = 0; apply(v); apply(v);
    v = idle_vec(); apply(v);

    // load-use on rs1D, then bubble clears it
    v = idle_vec(); v.mem_loadE = 3'b010; v.rdE = 5; v.rs1D = 5; apply(v);
    v = idle_vec(); apply(v);
    // rdE = x0 and non-load cases
    v = idle_vec(); v.mem_loadE = 3'b010; v.rdE = 0; v.rs1D = 0; apply(v);
    v = idle_vec(); v.mem_loadE = 0; v.rdE = 7; v.rs2D = 7; apply(v);
    // taken branch beats load-use
    v = idle_vec(); v.mem_loadE = 3'b010; v.rdE = 5; v.rs2D = 5; v.br = 1; apply(v);
    // long op held 4 cycles, branch pulsed mid-stall
    for (int i = 0; i < 4; i++) begin
      v = idle_vec(); v.lstart = 1; v.br = (i == 1); apply(v);
    end
    v = idle_vec(); apply(v);
    // forwarding priority
    v = idle_vec(); v.rs1E = 9; v.rdM = 9; v.rdW = 9; v.wM = 1; v.wW = 1; apply(v);
    v.wM = 0; apply(v);
    v.rdM = 0; v.rdW = 0; v.wM = 1; apply(v);
    // reset while BUSY
    v = idle_vec(); v.lstart = 1; apply(v); apply(v);
    v = idle_vec(); v.rstn = 0; v.lstart = 1; apply(v);
    v = idle_vec(); apply(v);
    // five load-use stalls
    for (int i = 0; i < 5; i++) begin
      v = idle_vec(); v.mem_loadE = 3'b100; v.rdE = 7; v.rs2D = 7; apply(v);
      v = idle_vec(); apply(v);
    end

    for (int i = 0; i < 600; i++) begin
      v.rstn      = ($urandom_range(0, 59) != 0);
      v.rs1D      = pick_reg(); v.rs2D = pick_reg();
      v.rs1E      = pick_reg(); v.rs2E = pick_reg();
      v.rdE       = pick_reg(); v.rdM  = pick_reg(); v.rdW = pick_reg();
      v.mem_loadE = ($urandom_range(0, 1) != 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      v.br        = ($urandom_range(0, 5) == 0);
      v.lstart    = ($urandom_range(0, 7) == 0);
      v.wM        = 1'($urandom_range(0, 1));
      v.wW        = 1'($urandom_range(0, 1));
      apply(v);
    end

    guard = 0;
    while (sb.size() > 0 && guard < 20) begin
      @(posedge CLK);
      guard++;
    end
    if (sb.size() > 0) begin
      n_fail++;
      $display("FAIL drain actual=%0d pending required=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
